// File: rtl/l1_mem_serializer_pkg.sv
// l1_mem_serializer_pkg: shared memory opcodes, serializer FSM state type, beat-count helper
//   MEM_LW / MEM_SW : opcode constants (any opcode other than MEM_LW is a store)
//   state_t         : IDLE, READ, WRITE, RSP
//   n_beats()       : beats per line from log2(line bytes) and log2(beat bits)
package l1_mem_serializer_pkg;
    localparam logic [4:0] MEM_LW = 5'd2;
    localparam logic [4:0] MEM_SW = 5'd3;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RSP} state_t;
    function automatic int n_beats(input int lg_line_bytes, input int lg_beat_bits);
        return 2 ** (lg_line_bytes + 3 - lg_beat_bits);
    endfunction
endpackage

// File: rtl/l1_mem_serializer_if.sv
// l1_mem_serializer_if: L1 line port plus narrow beat bus seen by the serializer
//   slave  : the serializer (takes line requests, drives beats and responses)
//   master : the environment (L1 cache and external beat bus)
//   Request : mem_req_valid/ack/addr/store_data/opcode/tag
//   Response: mem_rsp_valid/load_data/opcode/tag/err
//   Beat bus: is_write, addr, d_out/d_out_valid/d_out_ready, d_in/d_in_valid, busy
interface l1_mem_serializer_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int BEAT_W = 16,
    parameter int TAG_W  = 4
);
    import l1_mem_serializer_pkg::*;
    logic              mem_req_valid;
    logic              mem_req_ack;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_store_data;
    logic [4:0]        mem_req_opcode;
    logic [TAG_W-1:0]  mem_req_tag;
    logic              mem_rsp_valid;
    logic [LINE_W-1:0] mem_rsp_load_data;
    logic [4:0]        mem_rsp_opcode;
    logic [TAG_W-1:0]  mem_rsp_tag;
    logic              mem_rsp_err;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] d_out;
    logic              d_out_valid;
    logic              d_out_ready;
    logic [BEAT_W-1:0] d_in;
    logic              d_in_valid;
    logic              busy;
    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_opcode, mem_req_tag,
               d_out_ready, d_in, d_in_valid,
        output mem_req_ack, mem_rsp_valid, mem_rsp_load_data, mem_rsp_opcode, mem_rsp_tag,
               mem_rsp_err, is_write, addr, d_out, d_out_valid, busy
    );
    modport master (
        output mem_req_valid, mem_req_addr, mem_req_store_data, mem_req_opcode, mem_req_tag,
               d_out_ready, d_in, d_in_valid,
        input  mem_req_ack, mem_rsp_valid, mem_rsp_load_data, mem_rsp_opcode, mem_rsp_tag,
               mem_rsp_err, is_write, addr, d_out, d_out_valid, busy
    );
endinterface

// File: rtl/l1_mem_serializer_line_beat_buf.sv
// line_beat_buf: one cache-line register with full-line load and indexed beat write/read
//   load_i/line_i        : replace the whole line (wins over a beat write)
//   wr_en_i/idx/data     : overwrite beat wr_idx_i (beat 0 = bits [BEAT_W-1:0])
//   rd_idx_i/rd_data_o   : combinational beat read
//   line_o               : current line contents
module line_beat_buf
    import l1_mem_serializer_pkg::*;
#(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 16,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [BEAT_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [BEAT_W-1:0] rd_data_o,
    output logic [LINE_W-1:0] line_o
);
    logic [LINE_W-1:0] line_q, line_d;
    always_comb begin
        line_d = line_q;
        if (wr_en_i) line_d[int'(wr_idx_i) * BEAT_W +: BEAT_W] = wr_data_i;
        if (load_i) line_d = line_i;
    end
    always_ff @(posedge clk) line_q <= reset ? '0 : line_d;
    assign rd_data_o = line_q[int'(rd_idx_i) * BEAT_W +: BEAT_W];
    assign line_o = line_q;
endmodule

// File: rtl/l1_mem_serializer.sv
// l1_mem_serializer: bridges one-line L1 memory requests onto a narrow beat bus
//   clk, reset : clock, synchronous active-high reset
//   bus        : l1_mem_serializer_if.slave (request, response and beat-bus signals)
//   Optional   : MEM_SER_TIMEOUT_EN ends a stalled transfer after TIMEOUT_CYCLES idle
//                cycles with mem_rsp_err set and the partially filled line returned
module l1_mem_serializer
    import l1_mem_serializer_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int LG_BEAT_BITS   = 4,
    parameter int LG_LINE_BYTES  = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clk,
    input logic reset,
    l1_mem_serializer_if.slave bus
);
    localparam int BEAT_W = 2 ** LG_BEAT_BITS;
    localparam int LINE_W = 8 * (2 ** LG_LINE_BYTES);
    localparam int N_BEATS = n_beats(LG_LINE_BYTES, LG_BEAT_BITS);
    localparam int IDX_W = $clog2(N_BEATS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << LG_LINE_BYTES) - 1);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BEAT_W / 8);

    if (N_BEATS < 2 || (N_BEATS & (N_BEATS - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
        $error("l1_mem_serializer: beats per line must be a power of two >= 2");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [4:0]        op_q, op_d;
    logic              wr_q, wr_d;
    logic              accept, active, xfer, last, to_hit;
    logic [LINE_W-1:0] line;
    logic [BEAT_W-1:0] rd_beat;

    assign accept = state_q == IDLE && bus.mem_req_valid;
    assign active = state_q == READ || state_q == WRITE;
    assign xfer = (state_q == WRITE && bus.d_out_ready) || (state_q == READ && bus.d_in_valid);
    assign last = cnt_q == CNT_W'(N_BEATS - 1);

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        tag_d = tag_q;
        op_d = op_q;
        wr_d = wr_q;
        case (state_q)
            IDLE: if (accept) begin
                cnt_d = '0;
                addr_d = bus.mem_req_addr & ~LINE_MASK;
                tag_d = bus.mem_req_tag;
                op_d = bus.mem_req_opcode;
                wr_d = bus.mem_req_opcode != MEM_LW;
                state_d = (bus.mem_req_opcode != MEM_LW) ? WRITE : READ;
            end
            READ, WRITE: if (xfer) begin
                cnt_d = cnt_q + 1'b1;
                addr_d = addr_q + BEAT_BYTES;
                state_d = last ? RSP : state_q;
            end else if (to_hit) begin
                state_d = RSP;
            end
            RSP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            addr_q <= '0;
            tag_q <= '0;
            op_q <= '0;
            wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            addr_q <= addr_d;
            tag_q <= tag_d;
            op_q <= op_d;
            wr_q <= wr_d;
        end
    end

    // Store data is loaded on every accept; for loads each beat then overwrites its slot.
    line_beat_buf #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .IDX_W(IDX_W)) u_buf (
        .clk(clk),
        .reset(reset),
        .load_i(accept),
        .line_i(bus.mem_req_store_data),
        .wr_en_i(state_q == READ && bus.d_in_valid),
        .wr_idx_i(cnt_q[IDX_W-1:0]),
        .wr_data_i(bus.d_in),
        .rd_idx_i(cnt_q[IDX_W-1:0]),
        .rd_data_o(rd_beat),
        .line_o(line)
    );

`ifdef MEM_SER_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [ST_W-1:0] stall_q, stall_d;
    logic            err_q, err_d;
    // Counts consecutive transfer-free cycles; it is zero on entry because IDLE keeps it cleared.
    always_comb begin
        stall_d = (active && !xfer) ? stall_q + 1'b1 : '0;
        to_hit = active && !xfer && stall_q == ST_W'(TIMEOUT_CYCLES - 1);
        err_d = accept ? 1'b0 : (to_hit ? 1'b1 : err_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            err_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q <= err_d;
        end
    end
    assign bus.mem_rsp_err = state_q == RSP && err_q;
`else
    assign to_hit = 1'b0;
    assign bus.mem_rsp_err = 1'b0;
`endif

    assign bus.mem_req_ack = state_q == IDLE;
    assign bus.mem_rsp_valid = state_q == RSP;
    assign bus.mem_rsp_load_data = line;
    assign bus.mem_rsp_opcode = op_q;
    assign bus.mem_rsp_tag = tag_q;
    assign bus.is_write = wr_q;
    assign bus.addr = addr_q;
    assign bus.d_out = rd_beat;
    assign bus.d_out_valid = state_q == WRITE;
    assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_l1_mem_serializer.sv
// tb_l1_mem_serializer: table-driven line transactions checked through beat and response scoreboards
module tb_l1_mem_serializer;
    import l1_mem_serializer_pkg::*;
    localparam int AW = 32;
    localparam int LW = 128;
    localparam int BW = 16;
    localparam int TW = 4;
    localparam int NB = 8;

    typedef struct {
        logic [4:0]    op;
        logic [AW-1:0] a;
        logic [TW-1:0] tag;
        logic [LW-1:0] line;
        int            gap;
        logic [AW-1:0] exp_base;
        int            exp_lat;
    } vec_t;
    typedef struct {
        logic [LW-1:0] line;
        logic [4:0]    op;
        logic [TW-1:0] tag;
        logic          err;
        int            acc;
        int            lmin;
        int            lmax;
    } rsp_t;
    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] d;
        logic          st;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    rsp_t rq[$];
    beat_t bq[$];
    rsp_t r_m;
    vec_t tab[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l1_mem_serializer_if #(.ADDR_W(AW), .LINE_W(LW), .BEAT_W(BW), .TAG_W(TW)) bus ();
    l1_mem_serializer #(
        .ADDR_W(AW), .LG_BEAT_BITS(4), .LG_LINE_BYTES(4), .TAG_W(TW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic chk(input string n, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [AW-1:0] base, input logic [LW-1:0] line, input logic st, input int n);
        for (int i = 0; i < n; i++) bq.push_back('{base + AW'(2 * i), line[16 * i +: 16], st});
    endtask

    task automatic req(input logic [4:0] op, input logic [AW-1:0] a, input logic [TW-1:0] tag,
                       input logic [LW-1:0] sd, output int acc, output bit ok);
        int n;
        n = 0;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_opcode = op;
        bus.mem_req_addr = a;
        bus.mem_req_tag = tag;
        bus.mem_req_store_data = sd;
        while (!bus.mem_req_ack && n < 20) begin
            tick();
            n++;
        end
        chk("req_ack", bus.mem_req_ack, 1);
        ok = bus.mem_req_ack;
        acc = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 64) begin
            tick();
            n++;
        end
        chk("drain_outstanding", rq.size() + bq.size(), 0);
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int acc, b, s;
        bit ok;
        req(v.op, v.a, v.tag, (v.op == MEM_LW) ? ~v.line : v.line, acc, ok);
        if (!ok) begin
            bus.mem_req_valid = 1'b0;
            return;
        end
        rq.push_back('{v.line, v.op, v.tag, 1'b0, acc, v.exp_lat, v.exp_lat});
        push_beats(v.exp_base, v.line, v.op != MEM_LW, NB);
        tick();
        bus.mem_req_valid = 1'b0;
        if (v.op == MEM_LW) begin
            for (int i = 0; i < NB; i++) begin
                bus.d_in_valid = 1'b1;
                bus.d_in = v.line[16 * i +: 16];
                tick();
                bus.d_in_valid = 1'b0;
                if (i < NB - 1) repeat (v.gap) tick();
            end
        end else begin
            b = 0;
            s = 0;
            while (b < NB) begin
                if (b == 4 && s < v.gap) begin
                    bus.d_out_ready = 1'b0;
                    s++;
                end else begin
                    bus.d_out_ready = 1'b1;
                    b++;
                end
                tick();
            end
            bus.d_out_ready = 1'b1;
        end
        drain();
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.d_out_valid) begin
                chk("store_beat_expected", bq.size() != 0, 1);
                if (bq.size() != 0) begin
                    chk("store_addr", bus.addr, bq[0].a);
                    chk("store_data", bus.d_out, bq[0].d);
                    chk("store_is_write", bus.is_write, bq[0].st);
                    if (bus.d_out_ready) void'(bq.pop_front());
                end
            end
            if (bus.d_in_valid && bus.busy && !bus.is_write && !bus.mem_rsp_valid) begin
                chk("load_beat_expected", bq.size() != 0, 1);
                if (bq.size() != 0) begin
                    chk("load_addr", bus.addr, bq[0].a);
                    chk("load_kind", bus.is_write, bq[0].st);
                    void'(bq.pop_front());
                end
            end
            if (bus.mem_rsp_valid) begin
                chk("rsp_expected", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    r_m = rq.pop_front();
                    chk("rsp_line", bus.mem_rsp_load_data, r_m.line);
                    chk("rsp_opcode", bus.mem_rsp_opcode, r_m.op);
                    chk("rsp_tag", bus.mem_rsp_tag, r_m.tag);
                    chk("rsp_err", bus.mem_rsp_err, r_m.err);
                    chk("rsp_latency_in_window", (cyc - r_m.acc >= r_m.lmin) && (cyc - r_m.acc <= r_m.lmax), 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit ok;
        tab[0] = '{MEM_SW, 32'h0000_1004, 4'h1, 128'h000F_000D_000B_0009_0007_0005_0003_0001, 0, 32'h0000_1000, 9};
        tab[1] = '{MEM_LW, 32'h0000_2000, 4'h2, 128'hA007_A006_A005_A004_A003_A002_A001_A000, 1, 32'h0000_2000, 16};
        tab[2] = '{MEM_SW, 32'h0000_3000, 4'h3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3, 32'h0000_3000, 12};
        tab[3] = '{MEM_LW, 32'h0000_400A, 4'h4, 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0, 0, 32'h0000_4000, 9};
        tab[4] = '{5'h1F,  32'hFFFF_FFFF, 4'h5, 128'hFFFF_0000_AAAA_5555_0F0F_F0F0_3C3C_C3C3, 0, 32'hFFFF_FFF0, 9};
        tab[5] = '{MEM_LW, 32'h0000_000F, 4'hF, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 2, 32'h0000_0000, 23};
        bus.mem_req_valid = 1'b0;
        bus.mem_req_addr = '0;
        bus.mem_req_store_data = '0;
        bus.mem_req_opcode = '0;
        bus.mem_req_tag = '0;
        bus.d_out_ready = 1'b1;
        bus.d_in = '0;
        bus.d_in_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", bus.mem_rsp_valid, 0);
        chk("reset_rsp_err", bus.mem_rsp_err, 0);
        chk("reset_d_out_valid", bus.d_out_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_ack", bus.mem_req_ack, 1);
        chk("reset_is_write", bus.is_write, 0);
        chk("reset_addr", bus.addr, 0);
        tick();
        bus.d_in_valid = 1'b1;
        bus.d_in = 16'h5A5A;
        repeat (2) tick();
        bus.d_in_valid = 1'b0;
        chk("idle_d_in_busy", bus.busy, 0);
        chk("idle_d_in_addr", bus.addr, 0);

        for (int i = 0; i < 6; i++) run_vec(tab[i]);

        req(MEM_SW, 32'h0000_6000, 4'h7, 128'h0101_0202_0303_0404_0505_0606_0707_0808, acc, ok);
        if (ok) begin
            rq.push_back('{128'h0101_0202_0303_0404_0505_0606_0707_0808, MEM_SW, 4'h7, 1'b0, acc, 9, 9});
            push_beats(32'h0000_6000, 128'h0101_0202_0303_0404_0505_0606_0707_0808, 1'b1, NB);
            rq.push_back('{128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F, 5'h1F, 4'h8, 1'b0, acc + 10, 9, 9});
            push_beats(32'h0000_7000, 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F, 1'b1, NB);
            tick();
            bus.mem_req_opcode = 5'h1F;
            bus.mem_req_addr = 32'h0000_7006;
            bus.mem_req_tag = 4'h8;
            bus.mem_req_store_data = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;
            for (int c = 1; c < 10; c++) begin
                @(negedge clk);
                chk("b2b_ack_while_busy", bus.mem_req_ack, 0);
                tick();
            end
            chk("b2b_ack_after_rsp", bus.mem_req_ack, 1);
            tick();
        end
        bus.mem_req_valid = 1'b0;
        drain();

        req(MEM_LW, 32'h0000_5000, 4'h6, '0, acc, ok);
        tick();
        bus.mem_req_valid = 1'b0;
        if (ok) begin
            push_beats(32'h0000_5000, 128'h0, 1'b0, 3);
            for (int i = 0; i < 3; i++) begin
                bus.d_in_valid = 1'b1;
                bus.d_in = 16'hC000 + 16'(i);
                tick();
            end
            bus.d_in = 16'hC003;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            bus.d_in_valid = 1'b0;
            chk("reset_mid_beats_seen", bq.size(), 0);
            bq.delete();
            @(negedge clk);
            chk("abort_busy", bus.busy, 0);
            chk("abort_ack", bus.mem_req_ack, 1);
            chk("abort_rsp_valid", bus.mem_rsp_valid, 0);
            repeat (12) tick();
        end
        run_vec(tab[1]);

`ifdef MEM_SER_TIMEOUT_EN
        req(MEM_LW, 32'h0000_8000, 4'h9, '0, acc, ok);
        if (ok) begin
            rq.push_back('{{96'h0, 16'hB001, 16'hB000}, MEM_LW, 4'h9, 1'b1, acc, 18, 19});
            push_beats(32'h0000_8000, {96'h0, 16'hB001, 16'hB000}, 1'b0, 2);
        end
        tick();
        bus.mem_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.d_in_valid = 1'b1;
            bus.d_in = 16'hB000 + 16'(i);
            tick();
        end
        bus.d_in_valid = 1'b0;
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l1_mem_serializer.md
Name: l1_mem_serializer

Overview:
- Parametrised bridge between the L1 cache-line memory port (one full line per request) and a narrow external beat bus.
- Successor to the fixed 16-bit/8-beat line serializer; line and beat widths are generic.
- Adds backpressure on writes (d_out_ready), a real request handshake (ack only when idle), and a tag return path.
- Sits between core_l1d_l1i and the external memory/monitor bus at the top-level wrapper.

Parameters:
- ADDR_W, 32, address width (M_WIDTH).
- LG_BEAT_BITS, 4, log2 of beat width in bits (16-bit beats).
- LG_LINE_BYTES, 4, log2 of line size in bytes (16 B).
- TAG_W, 4, request tag width.
- TIMEOUT_CYCLES, 1024, stall limit; used only with MEM_SER_TIMEOUT_EN.
- Derived: BEAT_W = 2^LG_BEAT_BITS; LINE_W = 8 * 2^LG_LINE_BYTES; N_BEATS = LINE_W / BEAT_W (must be ≥2, power of 2).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- mem_req_valid, in, 1: line request present.
- mem_req_ack, out, 1: request accepted this cycle when high together with valid.
- mem_req_addr, in, ADDR_W: byte address.
- mem_req_store_data, in, LINE_W: store line.
- mem_req_opcode, in, 5: MEM_LW = load; any other value = store.
- mem_req_tag, in, TAG_W: echoed on response.
- mem_rsp_valid, out, 1: one-cycle response pulse.
- mem_rsp_load_data, out, LINE_W: assembled line.
- mem_rsp_opcode, out, 5: opcode of the completed request.
- mem_rsp_tag, out, TAG_W: tag of the completed request.
- mem_rsp_err, out, 1: timeout flag.
- is_write, out, 1: current transfer is a store.
- addr, out, ADDR_W: address of the current beat.
- d_out, out, BEAT_W: store beat data.
- d_out_valid, out, 1: store beat offered.
- d_out_ready, in, 1: bus takes the store beat.
- d_in, in, BEAT_W: load beat data.
- d_in_valid, in, 1: load beat present (no backpressure).
- busy, out, 1: state != IDLE.

Behaviour:
- Reset: state IDLE, cnt 0, buffer 0, addr 0, tag 0, opcode 0, is_write 0. Outputs after reset: mem_rsp_valid 0, mem_rsp_err 0, d_out_valid 0, busy 0, mem_req_ack 1.
- States: IDLE, READ, WRITE, RSP.
- IDLE:
  - mem_req_ack = 1 combinationally in IDLE only.
  - On valid&ack, latch buffer = store_data, opcode, tag, cnt = 0.
  - addr = mem_req_addr with its low LG_LINE_BYTES bits cleared (line-aligned).
  - is_write = (opcode != MEM_LW). Next state READ or WRITE.
- WRITE:
  - d_out_valid = 1; d_out = buffer beat[cnt] (beat 0 = bits [BEAT_W-1:0]).
  - A beat transfers when d_out_valid & d_out_ready: cnt++, addr += BEAT_W/8.
  - On the transfer with cnt == N_BEATS-1, go to RSP.
  - d_out and addr are held stable while ready is low.
- READ:
  - When d_in_valid, write buffer beat[cnt] = d_in, then cnt++ and addr += BEAT_W/8.
  - On the beat with cnt == N_BEATS-1, go to RSP.
  - d_in_valid outside READ is ignored.
- RSP:
  - mem_rsp_valid = 1 for exactly one cycle; load_data = buffer; opcode and tag = latched values.
  - For a store, load_data equals the original store data.
  - Next state IDLE; ack is not asserted during RSP.
- Latency with no stalls: accept at cycle 0, beats at cycles 1..N_BEATS, rsp at N_BEATS+1, next accept at N_BEATS+2.
- Counter and address widths:
  - cnt is LG(N_BEATS)+1 bits; the last-beat compare uses N_BEATS-1.
  - addr increments modulo 2^ADDR_W; wrap at the top of the address space is allowed.
- Reset mid-transfer aborts immediately: no response is produced and buffer contents are discarded.

Optional Feature:
- Macro: MEM_SER_TIMEOUT_EN.
- With it defined:
  - A stall counter clears on every beat transfer and on entry to READ/WRITE.
  - It increments each cycle in READ/WRITE without a transfer.
  - On reaching TIMEOUT_CYCLES, go to RSP with mem_rsp_err = 1 and load_data = the partial buffer.
- Without it: no counter exists, mem_rsp_err is tied to 0, and stalls are unbounded.

Decomposition:
- Shared package (existing machine/mem package) holds:
  - the MEM_LW/MEM_SW opcode constants;
  - state_t enum {IDLE, READ, WRITE, RSP};
  - the beat-count helper function.
- One sub-module: line_beat_buf. It holds the LINE_W register and provides indexed beat write (en, idx, data), indexed beat read, and full-line load.

Test Plan (BEAT_W=16, LINE_W=128, N_BEATS=8):
- Store at 0x1004 with data 0x000F...0001, d_out_ready always 1:
  - ack at cycle 0; beats 0x0001..0x000F on addr 0x1000..0x100E during cycles 1..8.
  - mem_rsp_valid at cycle 9 with the matching tag.
- Load at 0x2000, d_in_valid on alternate cycles with 0xA000+i:
  - rsp line = {0xA007,...,0xA000}, opcode MEM_LW.
  - addr advances only on valid beats.
- Store with d_out_ready low for 3 cycles at beat 4:
  - d_out = beat 4 and addr = base+8 held stable; total beats still 8; exactly one rsp.
- Back-to-back requests with mem_req_valid held high:
  - ack low during READ/WRITE/RSP; second request accepted the cycle after the rsp.
  - Tags are returned in order.
- Reset asserted at load beat 3:
  - next cycle busy = 0, ack = 1, no mem_rsp_valid.
  - A new load then completes normally.
- With MEM_SER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, load with only 2 beats delivered:
  - rsp with err = 1 16 cycles after the last beat; low 32 bits of the line hold the 2 beats.
